mgmt_irq_ctrl: RTL

MGMT_IRQ_CTRL -- requirements
Module: mgmt_irq_ctrl

---
 rtl/mgmt_irq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mgmt_irq_ctrl.sv
// Management interrupt controller: edge-captured PENDING/ENABLE with lowest-index CLAIM over a TL-UL register port.
// Optional TEST (write-1-to-set) register is compiled in with MGMT_IRQ_CTRL_TEST_EN.

package tlul_pkg;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module mgmt_irq_ctrl
   import tlul_pkg::*;
#(
   parameter int NumSrc = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumSrc-1:0] intr_src_i,
   input  tl_h2d_t           tl_i,
   output tl_d2h_t           tl_o,
   output logic              irq_external_o
);

`ifdef MGMT_IRQ_CTRL_TEST_EN
   localparam bit TestEn = 1'b1;
`else
   localparam bit TestEn = 1'b0;
`endif

   logic [NumSrc-1:0] src_q, src_d;
   logic [NumSrc-1:0] pend_q, pend_d;
   logic [NumSrc-1:0] en_q, en_d;
   logic              arm_q, arm_d;
   logic              irq_q, irq_d;

   logic              d_valid_q, d_valid_d;
   logic              d_error_q, d_error_d;
   logic [2:0]        d_opcode_q, d_opcode_d;
   logic [1:0]        d_size_q, d_size_d;
   logic [7:0]        d_source_q, d_source_d;
   logic [31:0]       d_data_q, d_data_d;

   logic              a_ready;
   logic              accept;
   logic              is_get, is_put, addr_ok, req_err, wr_en;
   logic [1:0]        reg_sel;
   logic [NumSrc-1:0] wdata, w1c, w1s, edge_det, pend_en;
   logic [31:0]       claim, rdata;
   logic              unused_a_data;

   // Only the low NumSrc data bits are meaningful; the rest are ignored.
   assign unused_a_data = ^tl_i.a_data;

   always_comb begin
      a_ready = !d_valid_q || tl_i.d_ready;
      accept  = tl_i.a_valid && a_ready;

      is_get  = (tl_i.a_opcode == Get);
      is_put  = (tl_i.a_opcode == PutFullData) && (tl_i.a_mask == 4'hF);
      addr_ok = (tl_i.a_address[31:4] == 28'h0) && (tl_i.a_address[1:0] == 2'b00);
      reg_sel = tl_i.a_address[3:2];
      req_err = !(is_get || is_put) || !addr_ok || ((reg_sel == 2'd2) && !TestEn);
      wr_en   = accept && is_put && !req_err;
      wdata   = tl_i.a_data[NumSrc-1:0];
   end

   always_comb begin
      pend_en = pend_q & en_q;
      claim   = '0;
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (pend_en[i]) begin
            claim = 32'(i + 1);
         end
      end

      // Read data reflects register state before this cycle's updates.
      rdata = '0;
      case (reg_sel)
         2'd0:    rdata[NumSrc-1:0] = pend_q;
         2'd1:    rdata[NumSrc-1:0] = en_q;
         2'd2:    rdata = '0;
         default: rdata = claim;
      endcase
   end

   always_comb begin
      // The first cycle after reset only loads history, so a level held through reset is not an edge.
      edge_det = intr_src_i & ~src_q & {NumSrc{arm_q}};
      src_d    = intr_src_i;
      arm_d    = 1'b1;

      w1c = (wr_en && (reg_sel == 2'd0)) ? wdata : '0;
      w1s = (wr_en && (reg_sel == 2'd2) && TestEn) ? wdata : '0;

      pend_d = (pend_q & ~w1c) | w1s | edge_det;
      en_d   = (wr_en && (reg_sel == 2'd1)) ? wdata : en_q;
      irq_d  = |pend_en;
   end

   always_comb begin
      d_valid_d  = d_valid_q;
      d_error_d  = d_error_q;
      d_opcode_d = d_opcode_q;
      d_size_d   = d_size_q;
      d_source_d = d_source_q;
      d_data_d   = d_data_q;
      if (accept) begin
         d_valid_d  = 1'b1;
         d_error_d  = req_err;
         d_opcode_d = is_get ? AccessAckData : AccessAck;
         d_size_d   = tl_i.a_size;
         d_source_d = tl_i.a_source;
         d_data_d   = (is_get && !req_err) ? rdata : 32'h0;
      end else if (tl_i.d_ready) begin
         d_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q      <= '0;
         pend_q     <= '0;
         en_q       <= '0;
         arm_q      <= 1'b0;
         irq_q      <= 1'b0;
         d_valid_q  <= 1'b0;
         d_error_q  <= 1'b0;
         d_opcode_q <= '0;
         d_size_q   <= '0;
         d_source_q <= '0;
         d_data_q   <= '0;
      end else begin
         src_q      <= src_d;
         pend_q     <= pend_d;
         en_q       <= en_d;
         arm_q      <= arm_d;
         irq_q      <= irq_d;
         d_valid_q  <= d_valid_d;
         d_error_q  <= d_error_d;
         d_opcode_q <= d_opcode_d;
         d_size_q   <= d_size_d;
         d_source_q <= d_source_d;
         d_data_q   <= d_data_d;
      end
   end

   always_comb begin
      tl_o          = '0;
      tl_o.d_valid  = d_valid_q;
      tl_o.d_opcode = d_opcode_q;
      tl_o.d_size   = d_size_q;
      tl_o.d_source = d_source_q;
      tl_o.d_data   = d_data_q;
      tl_o.d_error  = d_error_q;
      tl_o.a_ready  = a_ready;
   end

   assign irq_external_o = irq_q;

endmodule
